// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: walks main/side/pedestrian phases, starts one timer run per phase,
// and latches side-street and pedestrian requests until they are served.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_LEN      = 20,
    parameter int unsigned YELLOW_LEN     = 4,
    parameter int unsigned ALLRED_LEN     = 2,
    parameter int unsigned SIDE_GREEN_LEN = 12,
    parameter int unsigned WALK_LEN       = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       t_done,
    input  logic       t_flicker,
    output logic       t_start,
    output logic [4:0] t_length,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       ped_walk,
    output logic       ped_flash,
    output logic       ped_wait
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        WALK        = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALLRED_B    = 3'd6
    } state_t;

    localparam logic [4:0] GREEN_L      = 5'(GREEN_LEN);
    localparam logic [4:0] YELLOW_L     = 5'(YELLOW_LEN);
    localparam logic [4:0] ALLRED_L     = 5'(ALLRED_LEN);
    localparam logic [4:0] SIDE_GREEN_L = 5'(SIDE_GREEN_LEN);
    localparam logic [4:0] WALK_L       = 5'(WALK_LEN);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t     state_r;
    state_t     state_next_s;
    logic       enter_s;
    logic       phase_end_s;
    logic       init_go_r;
    logic       side_pending_r;
    logic       ped_pending_r;
    logic       t_start_r;
    logic [4:0] t_length_r;
    logic [2:0] main_lamp_r;
    logic [2:0] side_lamp_r;
    logic [4:0] length_next_s;
    logic [2:0] main_next_s;
    logic [2:0] side_next_s;
    logic       ped_walk_s;
    logic       ped_flash_s;

    // A done flag seen alongside our own start pulse belongs to the previous run.
    assign phase_end_s = t_done & ~t_start_r;

    // State, timer handshake, lamp and request-latch registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ALLRED_B;
            init_go_r      <= 1'b1;
            t_start_r      <= 1'b0;
            t_length_r     <= ALLRED_L;
            main_lamp_r    <= LAMP_RED;
            side_lamp_r    <= LAMP_RED;
            side_pending_r <= 1'b0;
            ped_pending_r  <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            init_go_r      <= 1'b0;
            t_start_r      <= enter_s;
            t_length_r     <= length_next_s;
            main_lamp_r    <= main_next_s;
            side_lamp_r    <= side_next_s;
            side_pending_r <= side_req | (side_pending_r & ~(enter_s & (state_next_s == SIDE_GREEN)));
            ped_pending_r  <= ped_req  | (ped_pending_r  & ~(enter_s & (state_next_s == WALK)));
        end
    end

    // Next-state selection; every entry (including MAIN_GREEN re-entry) raises enter_s.
    always_comb begin
        state_next_s = state_r;
        enter_s      = 1'b0;
        if (init_go_r) begin
            enter_s = 1'b1;
        end else if (phase_end_s) begin
            enter_s = 1'b1;
            case (state_r)
                MAIN_GREEN:  state_next_s = (side_pending_r | ped_pending_r) ? MAIN_YELLOW : MAIN_GREEN;
                MAIN_YELLOW: state_next_s = ALLRED_A;
                ALLRED_A:    state_next_s = ped_pending_r ? WALK : SIDE_GREEN;
                WALK:        state_next_s = ALLRED_B;
                SIDE_GREEN:  state_next_s = SIDE_YELLOW;
                SIDE_YELLOW: state_next_s = ALLRED_B;
                ALLRED_B:    state_next_s = side_pending_r ? SIDE_GREEN : MAIN_GREEN;
                default:     state_next_s = ALLRED_B;
            endcase
        end else begin
            state_next_s = state_r;
            enter_s      = 1'b0;
        end
    end

    // Run length and lamps for the upcoming state, plus the pedestrian lamps.
    always_comb begin
        length_next_s = ALLRED_L;
        main_next_s   = LAMP_RED;
        side_next_s   = LAMP_RED;
        case (state_next_s)
            MAIN_GREEN:  begin length_next_s = GREEN_L;      main_next_s = LAMP_GREEN;  end
            MAIN_YELLOW: begin length_next_s = YELLOW_L;     main_next_s = LAMP_YELLOW; end
            ALLRED_A:    length_next_s = ALLRED_L;
            WALK:        length_next_s = WALK_L;
            SIDE_GREEN:  begin length_next_s = SIDE_GREEN_L; side_next_s = LAMP_GREEN;  end
            SIDE_YELLOW: begin length_next_s = YELLOW_L;     side_next_s = LAMP_YELLOW; end
            ALLRED_B:    length_next_s = ALLRED_L;
            default:     length_next_s = ALLRED_L;
        endcase
        ped_walk_s  = (state_r == WALK) & ~t_flicker;
        ped_flash_s = (state_r == WALK) &  t_flicker;
    end

    assign t_start   = t_start_r;
    assign t_length  = t_length_r;
    assign main_lamp = main_lamp_r;
    assign side_lamp = side_lamp_r;
    assign ped_walk  = ped_walk_s;
    assign ped_flash = ped_flash_s;
    assign ped_wait  = ped_pending_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a behavioural countdown timer attached
// (optionally overridden by a stub that holds t_done high).
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       side_req;
    logic       ped_req;
    logic       t_done;
    logic       t_flicker;
    logic       t_start;
    logic [4:0] t_length;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       ped_walk;
    logic       ped_flash;
    logic       ped_wait;

    logic       stub_en;
    logic       stub_done;
    logic [4:0] tm_cnt;
    logic       tm_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .t_done    (t_done),
        .t_flicker (t_flicker),
        .t_start   (t_start),
        .t_length  (t_length),
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .ped_walk  (ped_walk),
        .ped_flash (ped_flash),
        .ped_wait  (ped_wait)
    );

    // Timer model: cycle k after the start cycle has done = (k >= L); flicker covers the last 5 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_cnt  <= 5'd31;
            tm_done <= 1'b0;
        end else if (t_start) begin
            tm_cnt  <= t_length - 5'd1;
            tm_done <= (t_length == 5'd1);
        end else if (!tm_done && tm_cnt != 5'd0) begin
            tm_cnt  <= tm_cnt - 5'd1;
            tm_done <= (tm_cnt == 5'd1);
        end
    end

    assign t_done    = stub_en ? stub_done : tm_done;
    assign t_flicker = ~t_start & (tm_cnt <= 5'd4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next t_start cycle, returning the number of cycles taken.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t_start !== 1'b1 && n < 200);
        chk({tag, "_seen"}, {31'd0, t_start}, 32'd1);
    endtask

    task automatic check_phase(input string tag, input int gap, input logic [4:0] len,
                               input logic [2:0] ml, input logic [2:0] sl, input logic pw);
        int n;
        wait_start(tag, n);
        chk({tag, "_gap"},  n, gap);
        chk({tag, "_len"},  {27'd0, t_length}, {27'd0, len});
        chk({tag, "_main"}, {29'd0, main_lamp}, {29'd0, ml});
        chk({tag, "_side"}, {29'd0, side_lamp}, {29'd0, sl});
        chk({tag, "_wait"}, {31'd0, ped_wait}, {31'd0, pw});
    endtask

    // Called at the WALK start cycle; ends at the following ALLRED_B start cycle.
    task automatic walk_check(input string tag);
        int walk_n;
        int flash_n;
        walk_n  = 0;
        flash_n = 0;
        for (int i = 0; i < 11; i++) begin
            chk({tag, "_walk"},  {31'd0, ped_walk},  {31'd0, ~t_flicker});
            chk({tag, "_flash"}, {31'd0, ped_flash}, {31'd0, t_flicker});
            if (ped_walk)  walk_n++;
            if (ped_flash) flash_n++;
            @(negedge clk);
        end
        chk({tag, "_walk_n"},  walk_n, 6);
        chk({tag, "_flash_n"}, flash_n, 5);
        chk({tag, "_arb_start"}, {31'd0, t_start}, 32'd1);
        chk({tag, "_arb_len"}, {27'd0, t_length}, 32'd2);
        chk({tag, "_after_walk"}, {30'd0, ped_walk, ped_flash}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        side_req  = 1'b0;
        ped_req   = 1'b0;
        stub_en   = 1'b0;
        stub_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", {31'd0, t_start}, 32'd0);
        chk("rst_len",   {27'd0, t_length}, 32'd2);
        chk("rst_lamps", {26'd0, main_lamp, side_lamp}, {26'd0, 6'b100_100});
        chk("rst_ped",   {29'd0, ped_walk, ped_flash, ped_wait}, 32'd0);

        // Reset release, idle cycling
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_start", {31'd0, t_start}, 32'd1);
        chk("init_len",   {27'd0, t_length}, 32'd2);
        check_phase("mg0", 3,  5'd20, 3'b001, 3'b100, 1'b0);
        check_phase("mg1", 21, 5'd20, 3'b001, 3'b100, 1'b0);
        check_phase("mg2", 21, 5'd20, 3'b001, 3'b100, 1'b0);

        // Side request in cycle 5 of main green
        repeat (5) @(negedge clk);
        side_req = 1'b1;
        @(negedge clk);
        side_req = 1'b0;
        check_phase("s_my",  15, 5'd4,  3'b010, 3'b100, 1'b0);
        check_phase("s_ara", 5,  5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("s_sg",  3,  5'd12, 3'b100, 3'b001, 1'b0);
        check_phase("s_sy",  13, 5'd4,  3'b100, 3'b010, 1'b0);
        check_phase("s_arb", 5,  5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("s_mg",  3,  5'd20, 3'b001, 3'b100, 1'b0);
        check_phase("s_mg2", 21, 5'd20, 3'b001, 3'b100, 1'b0);

        // Pedestrian request
        repeat (3) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("p_wait", {31'd0, ped_wait}, 32'd1);
        check_phase("p_my",   17, 5'd4,  3'b010, 3'b100, 1'b1);
        check_phase("p_ara",  5,  5'd2,  3'b100, 3'b100, 1'b1);
        check_phase("p_walk", 3,  5'd10, 3'b100, 3'b100, 1'b0);
        walk_check("p");
        check_phase("p_mg",   3,  5'd20, 3'b001, 3'b100, 1'b0);

        // Both requests pending: walk first, then side
        repeat (2) @(negedge clk);
        side_req = 1'b1;
        ped_req  = 1'b1;
        @(negedge clk);
        side_req = 1'b0;
        ped_req  = 1'b0;
        check_phase("b_my",   18, 5'd4,  3'b010, 3'b100, 1'b1);
        check_phase("b_ara",  5,  5'd2,  3'b100, 3'b100, 1'b1);
        check_phase("b_walk", 3,  5'd10, 3'b100, 3'b100, 1'b0);
        check_phase("b_arb",  11, 5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("b_sg",   3,  5'd12, 3'b100, 3'b001, 1'b0);
        check_phase("b_sy",   13, 5'd4,  3'b100, 3'b010, 1'b0);
        check_phase("b_arb2", 5,  5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("b_mg",   3,  5'd20, 3'b001, 3'b100, 1'b0);

        // Pedestrian request on the WALK entry edge and mid-WALK
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        check_phase("e_my",  18, 5'd4, 3'b010, 3'b100, 1'b1);
        check_phase("e_ara", 5,  5'd2, 3'b100, 3'b100, 1'b1);
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("e_walk_start", {31'd0, t_start}, 32'd1);
        chk("e_walk_len",   {27'd0, t_length}, 32'd10);
        chk("e_entry_wait", {31'd0, ped_wait}, 32'd1);
        repeat (4) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("e_mid_wait", {31'd0, ped_wait}, 32'd1);
        check_phase("e_arb",   6,  5'd2,  3'b100, 3'b100, 1'b1);
        check_phase("e_mg",    3,  5'd20, 3'b001, 3'b100, 1'b1);
        check_phase("e_my2",   21, 5'd4,  3'b010, 3'b100, 1'b1);
        check_phase("e_ara2",  5,  5'd2,  3'b100, 3'b100, 1'b1);
        check_phase("e_walk2", 3,  5'd10, 3'b100, 3'b100, 1'b0);
        check_phase("e_arb2",  11, 5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("e_mg2",   3,  5'd20, 3'b001, 3'b100, 1'b0);

        // Stub timer holding t_done high through the start cycle
        stub_en   = 1'b1;
        stub_done = 1'b1;
        @(negedge clk);
        chk("st_no_restart", {31'd0, t_start}, 32'd0);
        chk("st_main",       {29'd0, main_lamp}, 32'd1);
        check_phase("st1", 1, 5'd20, 3'b001, 3'b100, 1'b0);
        check_phase("st2", 2, 5'd20, 3'b001, 3'b100, 1'b0);
        stub_en   = 1'b0;
        stub_done = 1'b0;

        // Reach side green, then reset asynchronously mid-phase
        repeat (2) @(negedge clk);
        side_req = 1'b1;
        @(negedge clk);
        side_req = 1'b0;
        check_phase("r_my",  18, 5'd4,  3'b010, 3'b100, 1'b0);
        check_phase("r_ara", 5,  5'd2,  3'b100, 3'b100, 1'b0);
        check_phase("r_sg",  3,  5'd12, 3'b100, 3'b001, 1'b0);
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("r_wait_set", {31'd0, ped_wait}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_start", {31'd0, t_start}, 32'd0);
        chk("ar_len",   {27'd0, t_length}, 32'd2);
        chk("ar_lamps", {26'd0, main_lamp, side_lamp}, {26'd0, 6'b100_100});
        chk("ar_ped",   {29'd0, ped_walk, ped_flash, ped_wait}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr_start", {31'd0, t_start}, 32'd1);
        chk("rr_len",   {27'd0, t_length}, 32'd2);
        check_phase("rr_mg",  3,  5'd20, 3'b001, 3'b100, 1'b0);
        check_phase("rr_mg2", 21, 5'd20, 3'b001, 3'b100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
